// File: rtl/uart_tx_abaud.sv
// UART transmitter: 8N1 framing, LSB first, programmable bit period,
// optional 0x55 auto-baud sync character and one-cycle completion flag.
module uart_tx_abaud #(
    parameter int unsigned DIV_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tx_en,
    input  logic [DIV_W-1:0] brg,
    input  logic [7:0]       tx_data,
    input  logic             tx_sync,
    input  logic             tx_start,
    output logic             UxTX,
    output logic             busy,
    output logic             UxTXIF
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_DATA  = 3'd2,
        S_STOP  = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t           state, state_nx;
    logic [7:0]       sh, sh_nx;
    logic [2:0]       bcnt, bcnt_nx;
    logic [DIV_W-1:0] tcnt, tcnt_nx;
    logic [DIV_W-1:0] div, div_nx;
    logic             t_zero;

    assign t_zero = (tcnt == '0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
            sh    <= '0;
            bcnt  <= '0;
            tcnt  <= '0;
            div   <= '0;
        end else begin
            state <= state_nx;
            sh    <= sh_nx;
            bcnt  <= bcnt_nx;
            tcnt  <= tcnt_nx;
            div   <= div_nx;
        end
    end

    always_comb begin
        state_nx = state;
        sh_nx    = sh;
        bcnt_nx  = bcnt;
        tcnt_nx  = tcnt;
        div_nx   = div;
        case (state)
            // DONE accepts a new request exactly like IDLE, giving back-to-back frames
            S_IDLE, S_DONE: begin
                state_nx = S_IDLE;
                if (tx_start && tx_en) begin
                    div_nx   = brg;
                    tcnt_nx  = brg;
                    sh_nx    = tx_sync ? 8'h55 : tx_data;
                    state_nx = S_START;
                end
            end
            S_START: begin
                if (t_zero) begin
                    tcnt_nx  = div;
                    bcnt_nx  = '0;
                    state_nx = S_DATA;
                end else begin
                    tcnt_nx = tcnt - DIV_W'(1);
                end
            end
            S_DATA: begin
                if (t_zero) begin
                    sh_nx   = {1'b0, sh[7:1]};
                    tcnt_nx = div;
                    if (bcnt == 3'd7) begin
                        state_nx = S_STOP;
                    end else begin
                        bcnt_nx = bcnt + 3'd1;
                    end
                end else begin
                    tcnt_nx = tcnt - DIV_W'(1);
                end
            end
            S_STOP: begin
                if (t_zero) begin
                    state_nx = S_DONE;
                end else begin
                    tcnt_nx = tcnt - DIV_W'(1);
                end
            end
            default: state_nx = S_IDLE;
        endcase
        // Losing enable mid-frame abandons the frame without a completion flag
        if (!tx_en && (state == S_START || state == S_DATA || state == S_STOP)) begin
            state_nx = S_IDLE;
        end
    end

    always_comb begin
        UxTX   = 1'b1;
        busy   = 1'b0;
        UxTXIF = 1'b0;
        case (state)
            S_START: begin
                UxTX = 1'b0;
                busy = 1'b1;
            end
            S_DATA: begin
                UxTX = sh[0];
                busy = 1'b1;
            end
            S_STOP:  busy   = 1'b1;
            S_DONE:  UxTXIF = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: doc/uart_tx_abaud.md
# uart_tx_abaud

Transmit half of the UART link. Serialises one 8-bit character per request as an 8N1 frame on UxTX, LSB first, at a bit period set by a baud-rate divisor. It can also send the 0x55 auto-baud sync character that the far-end receiver's auto-baud detector measures. It sits between the host-side transmit register and the TX pin, and raises a one-cycle completion flag for the interrupt logic.

## Interface
- DIV_W, 16: width of the baud divisor; cycles per bit = brg + 1.
- clk  in  1  system clock; all state changes on its rising edge.
- rst  in  1  asynchronous, active-low reset.
- tx_en  in  1  transmitter enable; low holds or forces the block idle.
- brg  in  DIV_W  bit period minus one, in clk cycles; latched at frame start.
- tx_data  in  8  character to send; latched at frame start.
- tx_sync  in  1  when high with tx_start, send 0x55 instead of tx_data.
- tx_start  in  1  request strobe; accepted only in IDLE with tx_en=1.
- UxTX  out  1  serial line; idle and stop level high.
- busy  out  1  high from the cycle after acceptance through the last stop-bit cycle.
- UxTXIF  out  1  one-cycle pulse when a frame completes normally.

## Operation
- Datapath:
  - Shift register sh[7:0].
  - Bit counter bcnt[2:0].
  - Baud counter tcnt[DIV_W-1:0], counting down.
  - Latched divisor div[DIV_W-1:0].
- States:
  - IDLE: UxTX=1, busy=0. On tx_start & tx_en: div<=brg, sh<=tx_sync ? 8'h55 : tx_data, tcnt<=brg, go to START.
  - START: UxTX=0. At tcnt==0: tcnt<=div, bcnt<=0, go to DATA. Otherwise tcnt decrements.
  - DATA: UxTX=sh[0]. At tcnt==0: shift sh right, tcnt<=div. If bcnt==7 go to STOP, else bcnt increments.
  - STOP: UxTX=1. At tcnt==0 go to DONE.
  - DONE: UxTX=1, busy=0, UxTXIF=1 for this cycle only. Behaves as IDLE, including accepting tx_start. Then returns to IDLE.
- tx_sync has priority over tx_data. tx_data and tx_sync are ignored outside the accepting cycle.
- tx_start is ignored while busy=1 and while tx_en=0. There is no queueing; the request is dropped.
- brg and tx_data changes mid-frame have no effect; the latched copies are used.
- tx_en falling mid-frame aborts: next state IDLE, UxTX=1 next cycle, no UxTXIF.
- Reset mid-frame: UxTX=1, busy=0, UxTXIF=0 immediately (asynchronous); state returns to IDLE.
- Unused state encodings go to IDLE.
- Reset values: state=IDLE, UxTX=1, busy=0, UxTXIF=0, sh=0, bcnt=0, tcnt=0, div=0.
- All outputs are registered or decoded from state only; no combinational path from inputs to outputs.

## Timing
- With acceptance in cycle T and P = brg + 1:
  - Start bit on cycles T+1 .. T+P.
  - Data bit i (i = 0..7) on cycles T+1+(i+1)P .. T+(i+2)P.
  - Stop bit on cycles T+1+9P .. T+10P.
  - UxTXIF=1 and busy=0 at cycle T+10P+1.
- Frame length is 10P cycles, plus one DONE cycle.
- busy=1 exactly on cycles T+1 .. T+10P.
- Back-to-back: tx_start held high gives acceptance in the DONE cycle, and the next start bit begins at T+10P+2. Exactly one extra idle-high cycle separates frames.
- brg=0: one cycle per bit; the frame is 10 cycles.
- brg = all ones: P = 2^DIV_W; the counter must not overflow or wrap early.
- A 0x55 sync frame gives line pattern 0,1,0,1,0,1,0,1,0,1. It has exactly 5 falling edges, each 2P apart. This is the pattern the far-end auto-baud counter expects.

## Test plan
- Reset, then idle 20 cycles -> UxTX=1, busy=0, UxTXIF=0 throughout; no tx_start pulse causes activity while tx_en=0.
- brg=3, tx_data=0xA5, one tx_start pulse at T -> UxTX low T+1..T+4, then bits 1,0,1,0,0,1,0,1 in 4-cycle slots, high T+37..T+40; UxTXIF single pulse at T+41; busy high T+1..T+40.
- brg=2, tx_sync=1, tx_data=0x00 -> line toggles every 3 cycles for 10 slots (0x55 sent); 5 falling edges spaced 6 cycles; brg changed to 7 mid-frame has no effect.
- brg=0, tx_start held high for 3 frames, data 0xFF/0x00/0x81 -> each frame is 10 cycles; there is one high DONE cycle between frames; 3 UxTXIF pulses.
- tx_start pulsed again at T+5 during a frame -> ignored; exactly one frame and one UxTXIF.
- tx_en dropped at T+15 (brg=3) -> UxTX=1 and busy=0 from T+16, no UxTXIF. Repeat with rst pulsed low at T+15 -> UxTX=1, busy=0 asynchronously, and the next request transmits a correct frame.
